instr_fetch_unit: RTL and testbench

Front end of the 16-bit CPU and the producer side of the decode interface. Holds the PC and fetches instruction words over a req/ack instruction-memory interface. Presents each word to decode with a valid/ready handshake, including the 4-bit OPCODE the control unit consumes. Accepts branch redirects from the execute stage.

---
 rtl/instr_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Front end of the 16-bit CPU. Holds the PC, fetches instruction words over a
// req/ack instruction-memory interface and hands each word to decode over a
// valid/ready handshake together with its address and 4-bit opcode. Branch
// redirects from execute take priority over sequential PC advance.
//
// Optional build macro: FETCH_PERF_CNT_EN
//   Adds the StallCount output: a saturating 16-bit count of cycles spent
//   waiting for memory (REQ without ack) or for decode (HOLD without ready).
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 2
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Enable,
  output logic               IMemReq,
  output logic [ADDR_W-1:0]  IMemAddr,
  input  logic               IMemAck,
  input  logic [INSTR_W-1:0] IMemData,
  input  logic               Redirect,
  input  logic [ADDR_W-1:0]  RedirectPC,
  output logic               InstrValid,
  input  logic               InstrReady,
  output logic [INSTR_W-1:0] Instr,
  output logic [ADDR_W-1:0]  InstrPC,
  output logic [3:0]         OPCODE,
  output logic [ADDR_W-1:0]  PC
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        StallCount
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetchStateT;

  fetchStateT        state;
  logic              kill;       // in-flight fetch belongs to the squashed path
  logic [ADDR_W-1:0] targetPC;   // where the next fetch goes after this cycle
  logic [ADDR_W-1:0] seqPC;      // sequential successor of the current fetch
  logic              dropData;   // returning word must be discarded

  // Resolve the next fetch address: a redirect this cycle overrides the held PC.
  // NOTE: always_comb assigns every output unconditionally, so no latch is inferred.
  always_comb begin
    targetPC = Redirect ? RedirectPC : PC;
    seqPC    = IMemAddr + ADDR_W'(PC_STEP);
    dropData = kill | Redirect;
  end

  // Fetch FSM: owns the PC, the memory request and the decode-side output registers.
  // NOTE: every register here uses <= so all updates see pre-edge values of each other.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      PC         <= RESET_PC;
      IMemReq    <= 1'b0;
      IMemAddr   <= '0;
      InstrValid <= 1'b0;
      Instr      <= '0;
      InstrPC    <= '0;
      OPCODE     <= 4'h0;
      kill       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          PC <= targetPC;
          if (Enable) begin
            IMemAddr <= targetPC;
            IMemReq  <= 1'b1;
            state    <= REQ;
          end
        end

        REQ: begin
          if (IMemAck) begin
            if (dropData) begin
              // Word belongs to the abandoned path; restart at the new PC.
              kill <= 1'b0;
              PC   <= targetPC;
              if (Enable) begin
                IMemAddr <= targetPC;
              end else begin
                IMemReq <= 1'b0;
                state   <= IDLE;
              end
            end else begin
              Instr      <= IMemData;
              OPCODE     <= IMemData[INSTR_W-1 -: 4];
              InstrPC    <= IMemAddr;
              InstrValid <= 1'b1;
              PC         <= seqPC;
              IMemReq    <= 1'b0;
              state      <= HOLD;
            end
          end else if (Redirect) begin
            // The request in flight must still complete; just mark it stale.
            PC   <= RedirectPC;
            kill <= 1'b1;
          end
        end

        HOLD: begin
          // Either decode took the word or a redirect squashed it.
          if (InstrReady || Redirect) begin
            InstrValid <= 1'b0;
            PC         <= targetPC;
            if (Enable) begin
              IMemAddr <= targetPC;
              IMemReq  <= 1'b1;
              state    <= REQ;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating count of cycles stalled on memory or on decode back-pressure.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      StallCount <= '0;
    end else if (((state == REQ && !IMemAck) || (state == HOLD && !InstrReady)) &&
                 (StallCount != 16'hFFFF)) begin
      StallCount <= StallCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
// Directed cycle table for the fetch FSM corner cases, a few hand-written
// multi-cycle sequences (async reset, stall counter), then a randomized run
// checked against a program-order reference model.
module tb_instr_fetch_unit;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned INSTR_W = 16;

  logic               Clock;
  logic               Reset;
  logic               Enable;
  logic               IMemReq;
  logic [ADDR_W-1:0]  IMemAddr;
  logic               IMemAck;
  logic [INSTR_W-1:0] IMemData;
  logic               Redirect;
  logic [ADDR_W-1:0]  RedirectPC;
  logic               InstrValid;
  logic               InstrReady;
  logic [INSTR_W-1:0] Instr;
  logic [ADDR_W-1:0]  InstrPC;
  logic [3:0]         OPCODE;
  logic [ADDR_W-1:0]  PC;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]        StallCount;
`endif

  instr_fetch_unit #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .RESET_PC(16'h0000),
    .PC_STEP (2)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Enable    (Enable),
    .IMemReq   (IMemReq),
    .IMemAddr  (IMemAddr),
    .IMemAck   (IMemAck),
    .IMemData  (IMemData),
    .Redirect  (Redirect),
    .RedirectPC(RedirectPC),
    .InstrValid(InstrValid),
    .InstrReady(InstrReady),
    .Instr     (Instr),
    .InstrPC   (InstrPC),
    .OPCODE    (OPCODE),
    .PC        (PC)
`ifdef FETCH_PERF_CNT_EN
    ,
    .StallCount(StallCount)
`endif
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle: inputs applied after the falling edge, outputs sampled 1 after the rising edge.
  task automatic drive(input logic en, input logic ack, input logic [15:0] data,
                       input logic rdr, input logic [15:0] rdrPc, input logic rdy);
    @(negedge Clock);
    Enable     = en;
    IMemAck    = ack;
    IMemData   = data;
    Redirect   = rdr;
    RedirectPC = rdrPc;
    InstrReady = rdy;
    @(posedge Clock);
    #1;
  endtask

  typedef struct {
    logic        en;
    logic        ack;
    logic [15:0] data;
    logic        rdr;
    logic [15:0] rdrPc;
    logic        rdy;
    logic        expReq;
    logic [15:0] expAddr;
    logic        expValid;
    logic [15:0] expInstr;
    logic [15:0] expIpc;
    logic [15:0] expPc;
  } vecT;

  function automatic vecT vec(input logic en, input logic ack, input logic [15:0] data,
                              input logic rdr, input logic [15:0] rdrPc, input logic rdy,
                              input logic eReq, input logic [15:0] eAddr, input logic eValid,
                              input logic [15:0] eInstr, input logic [15:0] eIpc,
                              input logic [15:0] ePc);
    vecT r;
    r.en = en; r.ack = ack; r.data = data; r.rdr = rdr; r.rdrPc = rdrPc; r.rdy = rdy;
    r.expReq = eReq; r.expAddr = eAddr; r.expValid = eValid;
    r.expInstr = eInstr; r.expIpc = eIpc; r.expPc = ePc;
    return r;
  endfunction

  // Instruction memory contents for the randomized run: a fixed function of address.
  function automatic logic [15:0] memWord(input logic [15:0] a);
    logic [15:0] m;
    m = a * 16'h9E37;
    return m ^ 16'h5A3C;
  endfunction

  vecT vecs[$];

  logic        preReq;
  logic [15:0] preAddr;
  logic        preValid;
  logic [15:0] preInstr;
  logic [15:0] preIpc;
  logic [15:0] expectedNext;
  int          handshakes;

  initial begin
    // ---------------- directed table ----------------
    //                  en ack data     rdr rdrPc    rdy | req addr     vld instr    ipc      pc
    vecs.push_back(vec(1, 0, 16'h0000, 0, 16'h0000, 1,   1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(vec(1, 1, 16'h1234, 0, 16'h0000, 1,   0, 16'h0000, 1, 16'h1234, 16'h0000, 16'h0002));
    vecs.push_back(vec(1, 0, 16'h0000, 0, 16'h0000, 1,   1, 16'h0002, 0, 16'h1234, 16'h0000, 16'h0002));
    vecs.push_back(vec(1, 0, 16'h0000, 0, 16'h0000, 1,   1, 16'h0002, 0, 16'h1234, 16'h0000, 16'h0002));
    vecs.push_back(vec(1, 0, 16'h0000, 0, 16'h0000, 1,   1, 16'h0002, 0, 16'h1234, 16'h0000, 16'h0002));
    vecs.push_back(vec(1, 0, 16'h0000, 0, 16'h0000, 1,   1, 16'h0002, 0, 16'h1234, 16'h0000, 16'h0002));
    vecs.push_back(vec(1, 1, 16'hABCD, 0, 16'h0000, 0,   0, 16'h0002, 1, 16'hABCD, 16'h0002, 16'h0004));
    for (int i = 0; i < 4; i++)
      vecs.push_back(vec(1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0002, 1, 16'hABCD, 16'h0002, 16'h0004));
    vecs.push_back(vec(1, 0, 16'h0000, 0, 16'h0000, 1,   1, 16'h0004, 0, 16'hABCD, 16'h0002, 16'h0004));
    vecs.push_back(vec(1, 1, 16'h5555, 0, 16'h0000, 0,   0, 16'h0004, 1, 16'h5555, 16'h0004, 16'h0006));
    vecs.push_back(vec(1, 0, 16'h0000, 0, 16'h0000, 1,   1, 16'h0006, 0, 16'h5555, 16'h0004, 16'h0006));
    vecs.push_back(vec(1, 1, 16'h6666, 0, 16'h0000, 0,   0, 16'h0006, 1, 16'h6666, 16'h0006, 16'h0008));
    vecs.push_back(vec(1, 0, 16'h0000, 0, 16'h0000, 1,   1, 16'h0008, 0, 16'h6666, 16'h0006, 16'h0008));
    // redirect while REQ at 0x0008 awaits ack: stale word dropped
    vecs.push_back(vec(1, 0, 16'h0000, 1, 16'h0040, 1,   1, 16'h0008, 0, 16'h6666, 16'h0006, 16'h0040));
    vecs.push_back(vec(1, 0, 16'h0000, 0, 16'h0000, 1,   1, 16'h0008, 0, 16'h6666, 16'h0006, 16'h0040));
    vecs.push_back(vec(1, 1, 16'hDEAD, 0, 16'h0000, 1,   1, 16'h0040, 0, 16'h6666, 16'h0006, 16'h0040));
    vecs.push_back(vec(1, 1, 16'h7040, 0, 16'h0000, 0,   0, 16'h0040, 1, 16'h7040, 16'h0040, 16'h0042));
    // redirect in HOLD without ready: squash
    vecs.push_back(vec(1, 0, 16'h0000, 1, 16'h0100, 0,   1, 16'h0100, 0, 16'h7040, 16'h0040, 16'h0100));
    vecs.push_back(vec(1, 1, 16'h9100, 0, 16'h0000, 0,   0, 16'h0100, 1, 16'h9100, 16'h0100, 16'h0102));
    // handshake with Enable low: go idle and stay there
    vecs.push_back(vec(0, 0, 16'h0000, 0, 16'h0000, 1,   0, 16'h0100, 0, 16'h9100, 16'h0100, 16'h0102));
    vecs.push_back(vec(0, 0, 16'h0000, 0, 16'h0000, 1,   0, 16'h0100, 0, 16'h9100, 16'h0100, 16'h0102));
    // redirect in IDLE to 0xFFFE, then wrap to 0x0000
    vecs.push_back(vec(1, 0, 16'h0000, 1, 16'hFFFE, 1,   1, 16'hFFFE, 0, 16'h9100, 16'h0100, 16'hFFFE));
    vecs.push_back(vec(1, 1, 16'hF0F0, 0, 16'h0000, 0,   0, 16'hFFFE, 1, 16'hF0F0, 16'hFFFE, 16'h0000));
    vecs.push_back(vec(1, 0, 16'h0000, 0, 16'h0000, 1,   1, 16'h0000, 0, 16'hF0F0, 16'hFFFE, 16'h0000));
    // redirect in the same cycle as ack
    vecs.push_back(vec(1, 1, 16'h2222, 1, 16'h0080, 1,   1, 16'h0080, 0, 16'hF0F0, 16'hFFFE, 16'h0080));
    vecs.push_back(vec(1, 1, 16'h3080, 0, 16'h0000, 0,   0, 16'h0080, 1, 16'h3080, 16'h0080, 16'h0082));
    // redirect together with a completing handshake
    vecs.push_back(vec(1, 0, 16'h0000, 1, 16'h0200, 1,   1, 16'h0200, 0, 16'h3080, 16'h0080, 16'h0200));
    vecs.push_back(vec(1, 1, 16'h4200, 0, 16'h0000, 0,   0, 16'h0200, 1, 16'h4200, 16'h0200, 16'h0202));
    vecs.push_back(vec(1, 0, 16'h0000, 0, 16'h0000, 1,   1, 16'h0202, 0, 16'h4200, 16'h0200, 16'h0202));

    Reset = 1'b1; Enable = 1'b0; IMemAck = 1'b0; IMemData = '0;
    Redirect = 1'b0; RedirectPC = '0; InstrReady = 1'b0;
    #12;
    check("reset.IMemReq", IMemReq, 0);
    check("reset.InstrValid", InstrValid, 0);
    check("reset.PC", PC, 16'h0000);
    check("reset.IMemAddr", IMemAddr, 16'h0000);
    @(negedge Clock);
    Reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].ack, vecs[i].data, vecs[i].rdr, vecs[i].rdrPc, vecs[i].rdy);
      check($sformatf("row%0d.IMemReq", i), IMemReq, vecs[i].expReq);
      check($sformatf("row%0d.IMemAddr", i), IMemAddr, vecs[i].expAddr);
      check($sformatf("row%0d.InstrValid", i), InstrValid, vecs[i].expValid);
      check($sformatf("row%0d.Instr", i), Instr, vecs[i].expInstr);
      check($sformatf("row%0d.OPCODE", i), OPCODE, {28'h0, vecs[i].expInstr[15:12]});
      check($sformatf("row%0d.InstrPC", i), InstrPC, vecs[i].expIpc);
      check($sformatf("row%0d.PC", i), PC, vecs[i].expPc);
    end

    // ---------------- async reset in the middle of REQ ----------------
    #1;
    Reset = 1'b1;
    #1;
    check("asyncReset.IMemReq", IMemReq, 0);
    check("asyncReset.InstrValid", InstrValid, 0);
    check("asyncReset.PC", PC, 16'h0000);
    check("asyncReset.IMemAddr", IMemAddr, 16'h0000);
    check("asyncReset.Instr", Instr, 16'h0000);
    check("asyncReset.OPCODE", OPCODE, 0);
    @(negedge Clock);
    Reset = 1'b0; Enable = 1'b0; IMemAck = 1'b0; Redirect = 1'b0; InstrReady = 1'b0;

    // ---------------- 3-cycle ack delay, then decode back-pressure ----------------
    drive(1, 0, 16'h0000, 0, 16'h0000, 0);
    check("stall.enterReq", IMemReq, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 16'h0000, 0, 16'h0000, 0);
      check($sformatf("stall%0d.IMemReq", i), IMemReq, 1);
      check($sformatf("stall%0d.IMemAddr", i), IMemAddr, 16'h0000);
    end
    drive(1, 1, 16'h1111, 0, 16'h0000, 0);
    check("stall.InstrValid", InstrValid, 1);
    check("stall.Instr", Instr, 16'h1111);
    check("stall.OPCODE", OPCODE, 4'h1);
`ifdef FETCH_PERF_CNT_EN
    check("StallCount.afterAck", StallCount, 3);
`endif
    drive(1, 0, 16'h0000, 0, 16'h0000, 0);
    check("stall.holdValid", InstrValid, 1);
`ifdef FETCH_PERF_CNT_EN
    check("StallCount.afterHold", StallCount, 4);
`endif

    // ---------------- randomized run against a program-order model ----------------
    @(negedge Clock);
    Reset = 1'b1; Enable = 1'b0; IMemAck = 1'b0; Redirect = 1'b0; InstrReady = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;
    expectedNext = 16'h0000;
    handshakes = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge Clock);
      preReq   = IMemReq;
      preAddr  = IMemAddr;
      preValid = InstrValid;
      preInstr = Instr;
      preIpc   = InstrPC;
      Enable     = ($urandom_range(0, 7) != 0);
      InstrReady = ($urandom_range(0, 2) != 0);
      Redirect   = ($urandom_range(0, 11) == 0);
      RedirectPC = ($urandom_range(0, 3) == 0) ? 16'hFFFE : (16'($urandom) & 16'hFFFE);
      IMemAck    = IMemReq && ($urandom_range(0, 2) == 0);
      IMemData   = IMemAck ? memWord(IMemAddr) : 16'($urandom);

      // Accepted instructions must follow program order: sequential unless redirected.
      if (preValid && InstrReady) begin
        check($sformatf("rnd%0d.InstrPC", cyc), preIpc, expectedNext);
        check($sformatf("rnd%0d.Instr", cyc), preInstr, memWord(preIpc));
        check($sformatf("rnd%0d.OPCODE", cyc), OPCODE, {28'h0, preInstr[15:12]});
        expectedNext = preIpc + 16'd2;
        handshakes++;
      end
      if (Redirect) expectedNext = RedirectPC;

      @(posedge Clock);
      #1;
      if (preReq && !IMemAck) begin
        check($sformatf("rnd%0d.reqHeld", cyc), IMemReq, 1);
        check($sformatf("rnd%0d.addrHeld", cyc), IMemAddr, preAddr);
      end
      if (preValid && !InstrReady && !Redirect) begin
        check($sformatf("rnd%0d.validHeld", cyc), InstrValid, 1);
        check($sformatf("rnd%0d.instrHeld", cyc), Instr, preInstr);
        check($sformatf("rnd%0d.ipcHeld", cyc), InstrPC, preIpc);
      end
    end
    check("rnd.progress", (handshakes > 100) ? 32'd1 : 32'd0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
